// File: rtl/instr_encoder.sv
// Streaming MIPS instruction encoder: accepts decoded instruction requests and
// writes the assembled 32-bit words to consecutive instruction-memory addresses.
module instr_encoder #(
   parameter int DEPTH = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] base_addr,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_kind,
   input  logic [2:0]  in_alufn,
   input  logic [4:0]  in_rs,
   input  logic [4:0]  in_rt,
   input  logic [4:0]  in_rd,
   input  logic [15:0] in_imm,
   input  logic [25:0] in_target,
   input  logic        finish,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [15:0] count
);

   typedef enum logic [1:0] {IDLE, RUN, WRITE, DONE} state_t;

   localparam logic [16:0] DEPTH_L = 17'(DEPTH);

   state_t      state;
   logic [31:0] base;
   logic        accept;

   function automatic logic is_legal(input logic [2:0] kind, input logic [2:0] alufn);
      logic ok;
      ok = 1'b0;
      case (kind)
         3'd0: ok = (alufn == 3'b010) || (alufn == 3'b110) || (alufn == 3'b000) ||
                    (alufn == 3'b001) || (alufn == 3'b111);
         3'd1, 3'd2, 3'd3, 3'd4, 3'd5: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [5:0] funct_of(input logic [2:0] alufn);
      logic [5:0] f;
      case (alufn)
         3'b010:  f = 6'b100000;
         3'b110:  f = 6'b100010;
         3'b000:  f = 6'b100100;
         3'b001:  f = 6'b100101;
         3'b111:  f = 6'b101010;
         default: f = 6'b000000;
      endcase
      return f;
   endfunction

   function automatic logic [31:0] encode(input logic [2:0] kind, input logic [2:0] alufn,
                                          input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [15:0] imm,
                                          input logic [25:0] target);
      logic [31:0] w;
      case (kind)
         3'd0:    w = {6'b000000, rs, rt, rd, 5'b00000, funct_of(alufn)};
         3'd1:    w = {6'b100011, rs, rt, imm};
         3'd2:    w = {6'b101011, rs, rt, imm};
         3'd3:    w = {6'b000100, rs, rt, imm};
         3'd4:    w = {6'b001000, rs, rt, imm};
         3'd5:    w = {6'b000010, target};
         default: w = 32'd0;
      endcase
      return w;
   endfunction

   // Control decode straight from the state register so reset clears them at once
   assign in_ready = (state == RUN) && ({1'b0, count} < DEPTH_L);
   assign accept   = in_valid && in_ready;
   assign mem_we   = (state == WRITE);
   assign busy     = (state == RUN) || (state == WRITE);
   assign done     = (state == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         base      <= 32'd0;
         count     <= 16'd0;
         err       <= 1'b0;
         mem_addr  <= 32'd0;
         mem_wdata <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  base  <= base_addr;
                  count <= 16'd0;
                  err   <= 1'b0;
                  state <= RUN;
               end
            end
            RUN: begin
               // An accept wins over a simultaneous finish; the finish is lost
               if (accept) begin
                  if (is_legal(in_kind, in_alufn)) begin
                     mem_addr  <= base + {14'd0, count, 2'b00};
                     mem_wdata <= encode(in_kind, in_alufn, in_rs, in_rt, in_rd, in_imm, in_target);
                     state     <= WRITE;
                  end else begin
                     err <= 1'b1;
                  end
               end else if (finish) begin
                  state <= DONE;
               end
            end
            WRITE: begin
               count <= count + 16'd1;
               state <= RUN;
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed requests push expected writes,
// a monitor pops and compares on every mem_we cycle.
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, in_valid, finish;
   logic [31:0] base_addr;
   logic [2:0]  in_kind, in_alufn;
   logic [4:0]  in_rs, in_rt, in_rd;
   logic [15:0] in_imm;
   logic [25:0] in_target;
   logic        in_ready, mem_we, busy, done, err;
   logic [31:0] mem_addr, mem_wdata;
   logic [15:0] count;

   logic        s_start, s_valid, s_finish;
   logic        s_in_ready, s_mem_we, s_busy, s_done, s_err;
   logic [31:0] s_mem_addr, s_mem_wdata;
   logic [15:0] s_count;

   int          checks = 0;
   int          failures = 0;
   logic [63:0] sb_q[$];
   logic [31:0] exp_addr;

   always #5 clk = ~clk;

   instr_encoder #(.DEPTH(256)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_alufn(in_alufn),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm), .in_target(in_target),
      .finish(finish), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .busy(busy), .done(done), .err(err), .count(count)
   );

   instr_encoder #(.DEPTH(2)) dut_small (
      .clk(clk), .rst(rst), .start(s_start), .base_addr(base_addr),
      .in_valid(s_valid), .in_ready(s_in_ready), .in_kind(in_kind), .in_alufn(in_alufn),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm), .in_target(in_target),
      .finish(s_finish), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
      .busy(s_busy), .done(s_done), .err(s_err), .count(s_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Monitor: every write on the main encoder must match the oldest expectation
   initial begin
      logic [63:0] e;
      forever begin
         @(negedge clk);
         if (mem_we === 1'b1) begin
            if (sb_q.size() == 0) begin
               check("unexpected_write", mem_addr, 32'hxxxxxxxx);
            end else begin
               e = sb_q.pop_front();
               check("wr_addr", mem_addr, e[63:32]);
               check("wr_data", mem_wdata, e[31:0]);
            end
         end
      end
   end

   // Called at a negedge; returns two negedges after the accept (back in RUN)
   task automatic send(input logic [2:0] k, input logic [2:0] a, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                       input logic [25:0] tg, input logic [31:0] word, input bit legal,
                       input bit fin);
      int n = 0;
      in_kind = k; in_alufn = a; in_rs = rs; in_rt = rt; in_rd = rd;
      in_imm = imm; in_target = tg; in_valid = 1'b1; finish = fin;
      while (in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (in_ready !== 1'b1) begin
         check("ready_timeout", 32'd0, 32'd1);
         in_valid = 1'b0; finish = 1'b0;
         return;
      end
      if (legal) begin
         sb_q.push_back({exp_addr, word});
         exp_addr = exp_addr + 32'd4;
      end
      @(negedge clk);
      in_valid = 1'b0; finish = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_start(input logic [31:0] b);
      start = 1'b1; base_addr = b;
      @(negedge clk);
      start = 1'b0;
      exp_addr = b;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int writes;
      int dones;
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; finish = 1'b0; base_addr = 32'd0;
      in_kind = 3'd0; in_alufn = 3'd0; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0;
      in_imm = 16'd0; in_target = 26'd0;
      s_start = 1'b0; s_valid = 1'b0; s_finish = 1'b0;
      exp_addr = 32'd0;
      repeat (3) @(negedge clk);
      check("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_count", {16'd0, count}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // R-type and I/J-type words at consecutive addresses
      do_start(32'h100);
      check("run_ready", {31'd0, in_ready}, 32'd1);
      check("run_busy", {31'd0, busy}, 32'd1);
      send(3'd0, 3'b010, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 32'h00221820, 1, 0);
      check("count_after_add", {16'd0, count}, 32'd1);
      send(3'd0, 3'b110, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 32'h00221822, 1, 0);
      send(3'd0, 3'b111, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 32'h0022182A, 1, 0);
      send(3'd0, 3'b000, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 32'h00221824, 1, 0);
      send(3'd0, 3'b001, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 32'h00221825, 1, 0);
      send(3'd1, 3'b000, 5'd0, 5'd2, 5'd7, 16'h0004, 26'd0, 32'h8C020004, 1, 0);
      send(3'd3, 3'b000, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'd0, 32'h1022FFFF, 1, 0);
      send(3'd4, 3'b000, 5'd0, 5'd1, 5'd0, 16'h0005, 26'd0, 32'h20010005, 1, 0);
      send(3'd5, 3'b000, 5'd0, 5'd0, 5'd0, 16'd0, 26'h0000010, 32'h08000010, 1, 0);
      send(3'd2, 3'b000, 5'd4, 5'd5, 5'd0, 16'h0008, 26'd0, 32'hAC850008, 1, 0);
      check("count_after_10", {16'd0, count}, 32'd10);

      // Illegal requests: no write, sticky err, count held
      send(3'd6, 3'b000, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 32'd0, 0, 0);
      check("err_kind", {31'd0, err}, 32'd1);
      check("count_illegal_kind", {16'd0, count}, 32'd10);
      send(3'd0, 3'b011, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 32'd0, 0, 0);
      check("err_alufn", {31'd0, err}, 32'd1);
      check("count_illegal_alufn", {16'd0, count}, 32'd10);
      check("busy_after_illegal", {31'd0, busy}, 32'd1);

      // start is ignored while running
      start = 1'b1; base_addr = 32'hDEAD0000;
      @(negedge clk);
      start = 1'b0;
      send(3'd4, 3'b000, 5'd2, 5'd3, 5'd0, 16'h8000, 26'd0, 32'h20438000, 1, 0);
      check("count_after_legal", {16'd0, count}, 32'd11);

      finish = 1'b1;
      @(negedge clk);
      finish = 1'b0;
      check("done_pulse", {31'd0, done}, 32'd1);
      check("done_busy", {31'd0, busy}, 32'd0);
      check("err_sticky", {31'd0, err}, 32'd1);
      @(negedge clk);
      check("done_cleared", {31'd0, done}, 32'd0);
      check("idle_ready", {31'd0, in_ready}, 32'd0);

      // Address wrap, start clears err/count, accept beats finish
      do_start(32'hFFFFFFFC);
      check("start_clears_err", {31'd0, err}, 32'd0);
      check("start_clears_count", {16'd0, count}, 32'd0);
      send(3'd0, 3'b010, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 32'h00221820, 1, 0);
      send(3'd0, 3'b001, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 32'h00221825, 1, 1);
      check("finish_dropped_busy", {31'd0, busy}, 32'd1);
      check("finish_dropped_done", {31'd0, done}, 32'd0);
      finish = 1'b1;
      @(negedge clk);
      finish = 1'b0;
      check("done_pulse2", {31'd0, done}, 32'd1);
      @(negedge clk);

      // DEPTH=2 instance: three offers, only two writes
      do_start(32'h00000200);
      exp_addr = 32'd0;
      base_addr = 32'h200;
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      in_kind = 3'd4; in_alufn = 3'd0; in_rs = 5'd0; in_rt = 5'd1; in_imm = 16'h0005;
      s_valid = 1'b1;
      writes = 0;
      for (int i = 0; i < 12; i++) begin
         if (s_mem_we === 1'b1) begin
            check("small_addr", s_mem_addr, 32'h200 + 32'(4 * writes));
            check("small_data", s_mem_wdata, 32'h20010005);
            writes++;
         end
         @(negedge clk);
      end
      s_valid = 1'b0;
      check("small_writes", 32'(writes), 32'd2);
      check("small_count", {16'd0, s_count}, 32'd2);
      check("small_ready_full", {31'd0, s_in_ready}, 32'd0);
      s_finish = 1'b1;
      dones = 0;
      @(negedge clk);
      s_finish = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (s_done === 1'b1) dones++;
         @(negedge clk);
      end
      check("small_done_cycles", 32'(dones), 32'd1);
      check("small_idle_busy", {31'd0, s_busy}, 32'd0);

      // Main encoder still in RUN from the start above: reset during WRITE
      in_kind = 3'd0; in_alufn = 3'b010; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd3;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      check("mid_write_we", {31'd0, mem_we}, 32'd1);
      rst = 1'b1;
      #1;
      in_valid = 1'b0;
      check("abort_we", {31'd0, mem_we}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_count", {16'd0, count}, 32'd0);
      check("abort_addr", mem_addr, 32'd0);
      check("abort_wdata", mem_wdata, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_count", {16'd0, count}, 32'd0);
      check("post_rst_ready", {31'd0, in_ready}, 32'd0);
      do_start(32'h400);
      send(3'd0, 3'b010, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 32'h00221820, 1, 0);
      check("post_rst_count1", {16'd0, count}, 32'd1);

      @(negedge clk);
      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, giving the maximum number of words written per program.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: begin a program at base_addr; ignored unless in IDLE.
REQ-005 SHALL have port base_addr, input, 32 bits: first word address, sampled when start is accepted.
REQ-006 SHALL have port in_valid, input, 1 bit: instruction request present.
REQ-007 SHALL have port in_ready, output, 1 bit: encoder can accept a request.
REQ-008 SHALL have port in_kind, input, 3 bits: 0=R-type, 1=lw, 2=sw, 3=beq, 4=addi, 5=j; 6 and 7 are illegal.
REQ-009 SHALL have port in_alufn, input, 3 bits: R-type operation, using 010 add, 110 sub, 000 and, 001 or, 111 slt; other values are illegal.
REQ-010 SHALL have ports in_rs, in_rt, in_rd, input, 5 bits each: register fields.
REQ-011 SHALL have ports in_imm, input, 16 bits, and in_target, input, 26 bits: immediate field and jump target field.
REQ-012 SHALL have port finish, input, 1 bit: end the current program.
REQ-013 SHALL have ports mem_we, output, 1 bit; mem_addr, output, 32 bits; mem_wdata, output, 32 bits: the instruction-memory write port.
REQ-014 SHALL have ports busy, output, 1 bit; done, output, 1 bit; err, output, 1 bit; count, output, 16 bits.

Function
REQ-015 SHALL implement the states IDLE, RUN, WRITE and DONE.
- IDLE -> RUN on start.
- RUN -> WRITE on a legal accept.
- WRITE -> RUN after one cycle.
- RUN -> DONE on finish with no accept in that cycle.
- DONE -> IDLE after one cycle.
REQ-016 SHALL drive in_ready=1 only in RUN with count<DEPTH; an accept is in_valid && in_ready at a rising edge.
REQ-017 SHALL encode R-type as {000000, rs, rt, rd, 00000, funct}, with funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
REQ-018 SHALL encode lw, sw, beq and addi as {op, rs, rt, imm} with op 100011, 101011, 000100 and 001000 respectively; in_rd is ignored.
REQ-019 SHALL encode j as {000010, in_target}.
REQ-020 SHALL register the encoded word on accept and assert mem_we for exactly the following cycle (WRITE), with mem_addr = base_addr + 4*count and mem_wdata = the word; throughput is one word per 2 cycles.
REQ-021 SHALL increment count by 1 at the end of each WRITE cycle; mem_addr wraps modulo 2^32.
REQ-022 SHALL, on accept of an illegal kind or alufn, write nothing, set err (sticky until the next start or reset), leave count unchanged and remain in RUN.
REQ-023 SHALL, at count==DEPTH, hold in_ready=0; a finish is still honoured.
REQ-024 SHALL give an accept priority over a simultaneous finish; the finish is dropped and must be re-asserted.
REQ-025 SHALL ignore start outside IDLE; start in IDLE clears count and err.
REQ-026 SHALL drive busy=1 in RUN and WRITE, and pulse done=1 for exactly the one DONE cycle.
REQ-027 SHALL keep mem_we=0 in every state other than WRITE; mem_addr and mem_wdata are don't-care when mem_we=0.

Reset
REQ-028 SHALL, while rst=1, immediately force state=IDLE, mem_we=0, in_ready=0, busy=0, done=0, err=0, count=0, mem_addr=0 and mem_wdata=0.
REQ-029 SHALL abort any in-progress WRITE when rst is asserted mid-operation, with no partial write after rst rises; count retains 0 after release.

Verification
REQ-030 SHALL pass this scenario: start with base 0x100, then add rs=1 rt=2 rd=3 -> mem_we at 0x100 with 0x00221820 one cycle after accept, and count=1.
REQ-031 SHALL pass this sequence of accepts: lw rs=0 rt=2 imm=4, beq rs=1 rt=2 imm=0xFFFF, addi rs=0 rt=1 imm=5, j target=0x10 -> writes 0x8C020004, 0x1022FFFF, 0x20010005, 0x08000010 at consecutive addresses +0, +4, +8, +12.
REQ-032 SHALL pass this scenario: sub then slt with rs=1 rt=2 rd=3 -> 0x00221822 then 0x0022182A.
REQ-033 SHALL pass this scenario: in_kind=6, then in_alufn=011 -> no mem_we, err=1, count unchanged; a following legal request is still written.
REQ-034 SHALL pass this scenario: DEPTH=2, three requests offered -> two writes, then in_ready stays 0; finish -> done pulse for one cycle, then IDLE.
REQ-035 SHALL pass this scenario: rst raised during WRITE -> mem_we drops in the same cycle, all outputs reach their reset values, and start after release writes from the new base_addr.
